// File: rtl/mem_access_ctrl_pkg.sv
// Purpose: shared types and constants for the MAR/MDR memory access controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   state_t                - controller FSM state encoding
//   DEFAULT_TIMEOUT_CYCLES - default wait budget for mem_ready when the
//                            timeout build option (MEM_TIMEOUT_EN) is enabled
//   cnt_width()            - width helper for the wait counter
package slc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ACC = 2'd1,
        WR_ACC = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 15;

    // The counter only ever holds 0 .. limit-1, so clog2(limit) bits would do,
    // but a limit of 1 would then give a zero-width counter; keep at least 1 bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        int unsigned w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Purpose: memory-side port bundle between the access controller and a memory.
// Latency: n/a (wires only).
// Backpressure: memory stalls the controller by holding mem_ready low.
//
// Signals:
//   mem_addr  [15:0] controller -> memory, access address
//   mem_wdata [15:0] controller -> memory, write data
//   mem_ce           controller -> memory, access active
//   mem_we           controller -> memory, write strobe (only with mem_ce)
//   mem_rdata [15:0] memory -> controller, read data, valid with mem_ready
//   mem_ready        memory -> controller, current access completes this cycle
interface mem_access_ctrl_if;

    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ce;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_ce,
        output mem_we,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_ce,
        input  mem_we,
        output mem_rdata,
        output mem_ready
    );

endinterface

// File: rtl/mem_access_ctrl_reg_16.sv
// Purpose: 16-bit register with load enable and synchronous active-high reset.
// Latency: 1 cycle from ld to q.
// Backpressure: none.
//
// Ports:
//   Clk, Reset  clock and synchronous reset (reset wins over ld)
//   ld          load enable
//   d [15:0]    data in
//   q [15:0]    registered value
module reg_16 (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ld,
    input  logic [15:0] d,
    output logic [15:0] q
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q <= 16'h0000;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Purpose: MAR/MDR memory access controller; runs one read or write per request.
// Latency: request -> mem_ce next cycle; mem_ready -> done next cycle (>= 2 cycles total).
// Backpressure: memory stalls via mem_ready; requests/loads outside IDLE are dropped.
//
// Build option: define MEM_TIMEOUT_EN to abort an access after TIMEOUT_CYCLES
// access cycles without mem_ready (done and err pulse together, MDR kept).
// Without it the controller waits forever and err is tied low.
//
// Ports:
//   Clk, Reset        clock, synchronous active-high reset (highest priority)
//   bus_in [15:0]     datapath value for MAR/MDR loads
//   ld_mar, ld_mdr    load MAR / MDR from bus_in (IDLE only)
//   rd_req, wr_req    start read / write (IDLE only, read wins if both)
//   mem               memory-side bundle (mem_access_ctrl_if.master)
//   MAR, MDR [15:0]   address and data registers
//   busy              access in progress (RD_ACC / WR_ACC)
//   done              one-cycle completion pulse
//   err               one-cycle timeout pulse, coincident with done
module mem_access_ctrl
    import slc3_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [15:0]              bus_in,
    input  logic                     ld_mar,
    input  logic                     ld_mdr,
    input  logic                     rd_req,
    input  logic                     wr_req,
    mem_access_ctrl_if.master        mem,
    output logic [15:0]              MAR,
    output logic [15:0]              MDR,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    state_t      state;
    state_t      state_nxt;

    logic        mar_ld;
    logic        mdr_ld;
    logic [15:0] mdr_d;
    logic        in_access;
    logic        timeout_hit;

    // ------------------------------------------------------------------
    // Address and data registers
    // ------------------------------------------------------------------
    reg_16 u_mar (
        .Clk   (Clk),
        .Reset (Reset),
        .ld    (mar_ld),
        .d     (bus_in),
        .q     (MAR)
    );

    reg_16 u_mdr (
        .Clk   (Clk),
        .Reset (Reset),
        .ld    (mdr_ld),
        .d     (mdr_d),
        .q     (MDR)
    );

    assign in_access = (state == RD_ACC) || (state == WR_ACC);

    // ------------------------------------------------------------------
    // Optional wait counter
    // ------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // wait_cnt holds the zero-based index of the current access cycle; it sits
    // at 0 outside an access, so every access starts counting from 0.
    assign timeout_hit = in_access && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (in_access && !mem.mem_ready && !timeout_hit) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            // mem_ready in the last allowed cycle is a normal completion.
            err_q <= timeout_hit && !mem.mem_ready;
        end
    end

    assign err = err_q && (state == DONE);
`else
    // Parameter is kept for interface compatibility; it has no effect here.
    logic timeout_param_unused;
    assign timeout_param_unused = (TIMEOUT_CYCLES != 0);

    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mar_ld    = 1'b0;
        mdr_ld    = 1'b0;
        mdr_d     = bus_in;

        case (state)
            IDLE: begin
                // Loads and a request in the same cycle are fine: the access
                // starts next cycle, by which time MAR/MDR hold the new values.
                mar_ld = ld_mar;
                mdr_ld = ld_mdr;
                if (rd_req) begin
                    state_nxt = RD_ACC;
                end else if (wr_req) begin
                    state_nxt = WR_ACC;
                end
            end

            RD_ACC: begin
                if (mem.mem_ready) begin
                    mdr_ld    = 1'b1;
                    mdr_d     = mem.mem_rdata;
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                end
            end

            WR_ACC: begin
                if (mem.mem_ready || timeout_hit) begin
                    state_nxt = DONE;
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from state and registers only)
    // ------------------------------------------------------------------
    assign mem.mem_addr  = MAR;
    assign mem.mem_wdata = MDR;
    assign mem.mem_ce    = in_access;
    assign mem.mem_we    = (state == WR_ACC);
    assign busy          = in_access;
    assign done          = (state == DONE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Purpose: self-checking bench for mem_access_ctrl with directed and random transactions.
// Latency: n/a.
// Backpressure: bench memory model chooses mem_ready latency per transaction.
module tb_mem_access_ctrl;

    localparam int TMO = 15;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] bus_in;
    logic        ld_mar;
    logic        ld_mdr;
    logic        rd_req;
    logic        wr_req;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic        busy;
    logic        done;
    logic        err;

    mem_access_ctrl_if mif ();

    mem_access_ctrl dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .bus_in (bus_in),
        .ld_mar (ld_mar),
        .ld_mdr (ld_mdr),
        .rd_req (rd_req),
        .wr_req (wr_req),
        .mem    (mif),
        .MAR    (MAR),
        .MDR    (MDR),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Architectural model: what MAR and MDR must hold.
    logic [15:0] exp_mar = 16'h0000;
    logic [15:0] exp_mdr = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_in        = 16'h0000;
        ld_mar        = 1'b0;
        ld_mdr        = 1'b0;
        rd_req        = 1'b0;
        wr_req        = 1'b0;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = 16'h0000;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"},  err,  1'b0);
        chk({tag, "_ce"},   mif.mem_ce, 1'b0);
        chk({tag, "_we"},   mif.mem_we, 1'b0);
        chk({tag, "_mar"},  MAR, exp_mar);
        chk({tag, "_mdr"},  MDR, exp_mdr);
        chk({tag, "_addr"}, mif.mem_addr, exp_mar);
    endtask

    // One IDLE cycle of register loads.
    task automatic load(input bit lm, input bit lmd, input logic [15:0] v);
        ld_mar = lm;
        ld_mdr = lmd;
        bus_in = v;
        tick();
        clear_inputs();
        if (lm)  exp_mar = v;
        if (lmd) exp_mdr = v;
        chk("load_mar", MAR, exp_mar);
        chk("load_mdr", MDR, exp_mdr);
    endtask

    // A full transaction from IDLE: request cycle, (lat+1) access cycles with
    // mem_ready in the last one, one DONE cycle, then back in IDLE.
    task automatic access(input bit rd, input bit wr, input bit lm, input logic [15:0] v,
                          input int lat, input logic [15:0] rdata, input bit junk);
        bit is_wr;
        int busy_cnt;
        is_wr    = wr && !rd;
        busy_cnt = 0;

        chk("req_idle_busy", busy, 1'b0);
        rd_req = rd;
        wr_req = wr;
        ld_mar = lm;
        bus_in = v;
        if (lm) exp_mar = v;
        tick();
        clear_inputs();

        for (int k = 0; k <= lat; k++) begin
            chk("acc_ce",    mif.mem_ce, 1'b1);
            chk("acc_we",    mif.mem_we, is_wr);
            chk("acc_done",  done, 1'b0);
            chk("acc_err",   err, 1'b0);
            chk("acc_addr",  mif.mem_addr, exp_mar);
            chk("acc_mar",   MAR, exp_mar);
            chk("acc_wdata", mif.mem_wdata, exp_mdr);
            busy_cnt += int'(busy);
            if (junk) begin
                ld_mar = 1'b1;
                ld_mdr = 1'b1;
                bus_in = 16'hFFFF;
                rd_req = 1'($urandom);
                wr_req = 1'($urandom);
            end
            mif.mem_ready = (k == lat);
            mif.mem_rdata = (k == lat) ? rdata : 16'($urandom);
            tick();
            clear_inputs();
        end

        if (!is_wr) exp_mdr = rdata;
        chk("done_pulse", done, 1'b1);
        chk("done_busy",  busy, 1'b0);
        chk("done_ce",    mif.mem_ce, 1'b0);
        chk("done_err",   err, 1'b0);
        chk("done_mdr",   MDR, exp_mdr);
        chk("done_mar",   MAR, exp_mar);
        // Requests and loads presented in DONE must be dropped.
        if (junk) begin
            rd_req = 1'b1;
            wr_req = 1'b1;
            ld_mar = 1'b1;
            ld_mdr = 1'b1;
            bus_in = 16'($urandom);
        end
        tick();
        clear_inputs();
        chk("busy_cycles", busy_cnt, lat + 1);
        check_idle("post");
    endtask

    initial begin
        int busy_cnt;
        bit saw_done;

        clear_inputs();
        Reset = 1'b1;
        tick();
        tick();
        check_idle("reset");
        Reset = 1'b0;
        tick();
        check_idle("after_reset");

        // Read with same-cycle MAR load; memory answers in the 3rd access cycle.
        access(1'b1, 1'b0, 1'b1, 16'h3000, 2, 16'hBEEF, 1'b0);
        chk("rd_mdr_beef", MDR, 16'hBEEF);

        // Write with immediate mem_ready.
        load(1'b1, 1'b0, 16'h0042);
        load(1'b0, 1'b1, 16'h1234);
        access(1'b0, 1'b1, 1'b0, 16'h0000, 0, 16'h0000, 1'b0);
        chk("wr_mdr_kept", MDR, 16'h1234);

        // Simultaneous read and write requests: read only.
        access(1'b1, 1'b1, 1'b0, 16'h0000, 1, 16'hA5A5, 1'b0);

        // Loads and requests during the access and in DONE are ignored.
        access(1'b1, 1'b0, 1'b0, 16'h0000, 3, 16'h0F0F, 1'b1);

        // Both registers loaded in the same cycle.
        load(1'b1, 1'b1, 16'h7777);

        // mem_ready in the 15th access cycle completes normally.
        access(1'b1, 1'b0, 1'b0, 16'h0000, TMO - 1, 16'hC0DE, 1'b0);

        // Reset in the middle of a read beats every other input.
        rd_req = 1'b1;
        tick();
        clear_inputs();
        tick();
        chk("rst_mid_busy_before", busy, 1'b1);
        Reset         = 1'b1;
        ld_mar        = 1'b1;
        ld_mdr        = 1'b1;
        rd_req        = 1'b1;
        bus_in        = 16'hABCD;
        mif.mem_ready = 1'b1;
        mif.mem_rdata = 16'h5A5A;
        tick();
        clear_inputs();
        Reset   = 1'b0;
        exp_mar = 16'h0000;
        exp_mdr = 16'h0000;
        check_idle("rst_mid");
        tick();
        check_idle("rst_mid_next");

`ifdef MEM_TIMEOUT_EN
        // Memory never answers: abort after TMO access cycles with err.
        load(1'b0, 1'b1, 16'h2468);
        rd_req = 1'b1;
        tick();
        clear_inputs();
        busy_cnt = 0;
        saw_done = 1'b0;
        for (int k = 0; k < 40 && !saw_done; k++) begin
            if (done) begin
                saw_done = 1'b1;
            end else begin
                busy_cnt += int'(busy);
                tick();
            end
        end
        chk("tmo_seen",  saw_done, 1'b1);
        chk("tmo_busy",  busy_cnt, TMO);
        chk("tmo_err",   err, 1'b1);
        chk("tmo_mdr",   MDR, 16'h2468);
        tick();
        check_idle("tmo_post");
`else
        // No timeout: a long stall keeps waiting without err.
        access(1'b0, 1'b1, 1'b1, 16'h0100, 24, 16'h0000, 1'b0);
        busy_cnt = 0;
        saw_done = 1'b0;
        chk("long_wait_seen", saw_done, 1'b0);
        chk("long_wait_cnt", busy_cnt, 0);
`endif

        // Random transactions against the register-level model.
        for (int n = 0; n < 24; n++) begin
            logic [31:0] r;
            bit          rd;
            bit          wr;
            r = $urandom;
            if (r[0]) load(r[1], r[2], 16'($urandom));
            rd = r[3];
            wr = r[4] || !r[3];
            access(rd, wr, r[5], 16'($urandom), int'($urandom_range(0, 6)),
                   16'($urandom), r[6]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
